// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared sizes and loader state encoding for the Y86 instruction memory
package y86_pkg;

  localparam int IMEM_BYTES  = 1024;
  localparam int INSTR_BYTES = 10;
  localparam int ADDR_W      = 10;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/y86_imem_array.sv
// rtl/y86_imem_array.sv - 1024x8 byte store, one synchronous write port, ten-byte combinational fetch window
module y86_imem_array
  import y86_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [ADDR_W-1:0]          i_waddr,
  input  logic [7:0]                 i_wdata,
  input  logic [63:0]                i_raddr,
  output logic [8*INSTR_BYTES-1:0]   o_rdata
);

  logic [7:0] r_mem [IMEM_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // 65-bit sum so a fetch PC near 2^64 cannot wrap back into the array
  for (genvar gi = 0; gi < INSTR_BYTES; gi++) begin : g_rd
    logic [64:0] w_addr;
    assign w_addr = {1'b0, i_raddr} + 65'(gi);
    assign o_rdata[8*gi +: 8] = (w_addr < 65'(IMEM_BYTES)) ? r_mem[w_addr[ADDR_W-1:0]] : 8'h00;
  end

endmodule

// File: rtl/y86_imem_loader.sv
// rtl/y86_imem_loader.sv - streams a program into instruction memory; optional checksum under Y86_IMEM_CHECKSUM_EN
module y86_imem_loader
  import y86_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [ADDR_W-1:0]         i_base_addr,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [7:0]                i_in_data,
  input  logic                      i_in_last,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_load_err,
  output logic [10:0]               o_byte_count,
`ifdef Y86_IMEM_CHECKSUM_EN
  output logic [7:0]                o_checksum,
`endif
  input  logic [63:0]               i_rd_addr,
  output logic [8*INSTR_BYTES-1:0]  o_rd_data,
  output logic                      o_rd_err
);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [10:0]       r_byte_count;
  logic              r_load_err;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
`ifdef Y86_IMEM_CHECKSUM_EN
  logic [7:0]        r_checksum;
`endif

  logic w_xfer;
  logic w_at_top;

  // in_ready is only ever high in LOAD, so it doubles as the write qualifier
  assign w_xfer   = i_in_valid && r_in_ready;
  assign w_at_top = (r_wr_ptr == LAST_ADDR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_byte_count <= '0;
      r_load_err   <= 1'b0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef Y86_IMEM_CHECKSUM_EN
      r_checksum   <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state      <= ST_LOAD;
            r_wr_ptr     <= i_base_addr;
            r_byte_count <= '0;
            r_load_err   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b1;
`ifdef Y86_IMEM_CHECKSUM_EN
            r_checksum   <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_byte_count <= r_byte_count + 1'b1;
`ifdef Y86_IMEM_CHECKSUM_EN
            r_checksum   <= r_checksum + i_in_data;
`endif
            // the top byte closes the session rather than wrapping to address 0
            if (i_in_last || w_at_top) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_load_err <= !i_in_last;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  y86_imem_array u_array (
    .i_clk   (i_clk),
    .i_we    (w_xfer),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_in_data),
    .i_raddr (i_rd_addr),
    .o_rdata (o_rd_data)
  );

  assign o_rd_err     = (i_rd_addr > 64'(IMEM_BYTES - 1));
  assign o_in_ready   = r_in_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_load_err   = r_load_err;
  assign o_byte_count = r_byte_count;
`ifdef Y86_IMEM_CHECKSUM_EN
  assign o_checksum   = r_checksum;
`endif

endmodule
